// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
//   md_op_e    : funct3 encodings of the eight M-extension ops
//   md_state_e : sequencer states
//   is_div()   : true for DIV/DIVU/REM/REMU
//   MD_CYCLES  : iterations of the bit-serial datapath (one per operand bit)
package muldiv_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;
  localparam int unsigned MD_CYCLES     = MD_DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/execute_muldiv_ctrl.sv
// Execute-stage multi-cycle sequencer for RV32M.
// Iterative shift-add multiply / restoring divide on operand magnitudes,
// sign fix-up at the end. Holds the pipeline via stall_o until done.
//   clk, rst_n : clock, async active-low reset
//   valid_i    : ID/EX holds an M op; op_i (funct3), a_i (rs1), b_i (rs2)
//   flush_i    : abort current op, return to IDLE without a result
//   stall_o    : freeze PC, IF/ID, ID/EX
//   valid_o    : one-cycle pulse with result_o valid
//   result_o   : registered result, held until the next result
//   busy_o     : sequencer not in IDLE
module execute_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  // Raw rs2 until PREP, then the addend (multiplicand) or divisor magnitude.
  logic [DATA_WIDTH-1:0] b_q;
  // Product high half / partial remainder share this register.
  logic [DATA_WIDTH:0]   acc_hi;
  // Product low half (multiplier shifts out) / dividend-in, quotient-out.
  logic [DATA_WIDTH-1:0] acc_lo;
  logic                  neg_q;
  logic [CW-1:0]         cnt;

  md_op_e op_e;
  assign op_e = md_op_e'(op_q[2:0]);

  // Operand sign handling for PREP
  logic                  a_signed, b_signed, sa, sb;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic                  div_by_zero, overflow;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (op_e)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sa          = a_signed & a_q[DATA_WIDTH-1];
  assign sb          = b_signed & b_q[DATA_WIDTH-1];
  assign a_mag       = sa ? ('0 - a_q) : a_q;
  assign b_mag       = sb ? ('0 - b_q) : b_q;
  assign div_by_zero = is_div(op_e) & (b_q == '0);
  assign overflow    = ((op_e == OP_DIV) | (op_e == OP_REM)) &
                       (a_q == MIN_NEG) & (b_q == '1);

  // One iteration of each datapath
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH+1:0] div_diff;
  logic                  div_ok;

  assign mul_sum   = acc_lo[0] ? (acc_hi + {1'b0, b_q}) : acc_hi;
  assign div_shift = {acc_hi[DATA_WIDTH-1:0], acc_lo[DATA_WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
  assign div_ok    = ~div_diff[DATA_WIDTH+1];

  // Sign fix-up and result selection for FIX
  logic [2*DATA_WIDTH-1:0] prod, prod_s;
  logic [DATA_WIDTH-1:0]   quo_s, rem_s, fix_result;

  always_comb begin
    prod       = {acc_hi[DATA_WIDTH-1:0], acc_lo};
    prod_s     = neg_q ? ('0 - prod) : prod;
    quo_s      = neg_q ? ('0 - acc_lo) : acc_lo;
    rem_s      = neg_q ? ('0 - acc_hi[DATA_WIDTH-1:0]) : acc_hi[DATA_WIDTH-1:0];
    fix_result = '0;
    unique case (op_e)
      OP_MUL:                      fix_result = prod_s[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:             fix_result = quo_s;
      OP_REM, OP_REMU:             fix_result = rem_s;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and outputs
  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    busy_o  = (state_q != ST_IDLE);
    stall_o = valid_i & (state_q != ST_DONE) & ~flush_i;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (valid_i) state_d = ST_PREP;
        ST_PREP: state_d = (div_by_zero | overflow) ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt == CNT_LAST) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: begin
          valid_o = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath registers; a flush freezes everything, including result_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
    end else if (!flush_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
          end
        end
        ST_PREP: begin
          cnt    <= '0;
          acc_hi <= '0;
          if (is_div(op_e)) begin
            acc_lo <= a_mag;
            b_q    <= b_mag;
            neg_q  <= (op_e == OP_REM) ? sa : (sa ^ sb);
          end else begin
            acc_lo <= b_mag;
            b_q    <= a_mag;
            neg_q  <= sa ^ sb;
          end
          if (div_by_zero)
            result_o <= ((op_e == OP_REM) | (op_e == OP_REMU)) ? a_q : '1;
          else if (overflow)
            result_o <= (op_e == OP_DIV) ? MIN_NEG : '0;
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div(op_e)) begin
            acc_hi <= div_ok ? div_diff[DATA_WIDTH:0] : div_shift;
            acc_lo <= {acc_lo[DATA_WIDTH-2:0], div_ok};
          end else begin
            acc_hi <= {1'b0, mul_sum[DATA_WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
          end
        end
        ST_FIX:  result_o <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
module tb_execute_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_o, valid_o, busy_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  execute_muldiv_ctrl #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the RV32M arithmetic definitions
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 35;
  endfunction

  // Issue one op; return result, cycle of valid_o (-1 on timeout) and
  // whether stall_o was high before and low in the result cycle.
  // Operand inputs are scrambled after the accept cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic stall_ok);
    res = '0;
    lat = -1;
    stall_ok = 1'b1;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (valid_o) begin
        lat = k;
        res = result_o;
        if (stall_o) stall_ok = 1'b0;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
      if (k >= 1) begin
        a_i  = $urandom;
        b_i  = $urandom;
        op_i = 3'($urandom);
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    if (lat < 0) begin
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
    end
  endtask

  logic [31:0] res, held, ra, rb;
  logic [2:0]  rop;
  int          lat;
  logic        sok;
  logic        seen;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 35};
    vecs[1]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 35};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 35};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 35};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 35};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 35};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       35};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        35};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 2};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,        32'd5,        2};
    vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2};
    vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h0,        2};

    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid",  {31'b0, valid_o}, 32'd0);
    check("reset_busy",   {31'b0, busy_o},  32'd0);
    check("reset_stall",  {31'b0, stall_o}, 32'd0);
    check("reset_result", result_o,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, sok);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_stall", i), {31'b0, sok}, 32'd1);
    end

    // flush + valid together in IDLE: not accepted
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd3;
    #1;
    check("idle_flush_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check("idle_flush_busy", {31'b0, busy_o}, 32'd0);

    // flush at cycle 10 of a DIVU
    held = result_o;
    @(negedge clk);
    op_i = 3'd5; a_i = 32'd1000; b_i = 32'd9; valid_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    #1;
    check("flush_stall_now", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_busy_next", {31'b0, busy_o},  32'd0);
    check("flush_stall_next", {31'b0, stall_o}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    check("flush_no_valid", {31'b0, seen}, 32'd0);
    check("flush_result_held", result_o, held);

    // reset at cycle 20 of a MUL
    @(negedge clk);
    op_i = 3'd0; a_i = 32'd1234; b_i = 32'd5678; valid_i = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",  {31'b0, valid_o}, 32'd0);
    check("rst_mid_busy",   {31'b0, busy_o},  32'd0);
    check("rst_mid_result", result_o,         32'd0);
    check("rst_mid_stall",  {31'b0, stall_o}, 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b1;
    run_op(3'd0, 32'hFFFFFF85, 32'd5678, res, lat, sok);
    check("rst_after_result",  res, ref_res(3'd0, 32'hFFFFFF85, 32'd5678));
    check("rst_after_latency", 32'(lat), 32'd35);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(rop, ra, rb, res, lat, sok);
      check($sformatf("rnd%0d_op%0d_result", i, rop), res, ref_res(rop, ra, rb));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_lat(rop, ra, rb)));
      check($sformatf("rnd%0d_stall", i), {31'b0, sok}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
